// File: rtl/rx_line_fill_ctrl_if.sv
// Bus bundle between the SPI receive path and the frame-memory line-fill
// sequencer. The master drives RF traffic and frame control and receives the
// memory write port and status. The slave is the sequencer itself.
interface rx_line_fill_ctrl_if;
  // Receive-path side
  logic        FrameStart;
  logic        RxValid;
  logic [11:0] RxData;
  logic        RxAddValid;
  logic [15:0] RxAdd;
  logic        LinkLost;
  // Memory write port and status
  logic        MemWrEn;
  logic [15:0] MemWrAdd;
  logic [11:0] MemWrData;
  logic        FillActive;
  logic        FrameDone;
  logic        LineMissed;
  logic [9:0]  MissCount;

  modport master (
    output FrameStart, RxValid, RxData, RxAddValid, RxAdd, LinkLost,
    input  MemWrEn, MemWrAdd, MemWrData, FillActive, FrameDone, LineMissed, MissCount
  );

  modport slave (
    input  FrameStart, RxValid, RxData, RxAddValid, RxAdd, LinkLost,
    output MemWrEn, MemWrAdd, MemWrData, FillActive, FrameDone, LineMissed, MissCount
  );
endinterface

// File: rtl/rx_line_fill_ctrl.sv
// Receive frame-memory line-fill sequencer and write-port arbiter.
// RF payload words are written at the current line address. A watchdog
// declares a line missing after WD_TIMEOUT idle cycles, and the line is
// then filled with a constant value. RF words always take the single
// registered write port ahead of the filler.
// Optional build macro RX_FILL_MARK_EN: the fill value becomes 12'h00F
// (a visible marker) instead of 12'h000.
module rx_line_fill_ctrl #(
  parameter int unsigned LINE_LEN   = 80,
  parameter int unsigned NUM_LINES  = 480,
  parameter logic [19:0] WD_TIMEOUT = 20'h234FF
) (
  input logic               Cclk,
  input logic               rstn,
  rx_line_fill_ctrl_if.slave bus
);

  localparam logic [15:0] LINE_LEN_W  = 16'(LINE_LEN);
  localparam logic [15:0] FRAME_WORDS = 16'(LINE_LEN * NUM_LINES);

`ifdef RX_FILL_MARK_EN
  localparam logic [11:0] FILL_VALUE = 12'h00F;
`else
  localparam logic [11:0] FILL_VALUE = 12'h000;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] wr_add_q, wr_add_d;
  logic [15:0] next_line_q, next_line_d;
  logic [19:0] wd_q, wd_d;
  logic [15:0] fill_cnt_q, fill_cnt_d;
  logic [9:0]  miss_count_q, miss_count_d;
  logic        line_missed_q, line_missed_d;
  logic        mem_wr_en_q, mem_wr_en_d;
  logic [15:0] mem_wr_add_q, mem_wr_add_d;
  logic [11:0] mem_wr_data_q, mem_wr_data_d;

  logic        hdr_ok;
  logic [15:0] hdr_next_line;

  // Unsigned 16-bit add clamped at 0xFFFF so a line address never wraps.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Miss counter increment that sticks at its maximum.
  function automatic logic [9:0] sat_inc10(input logic [9:0] a);
    return (a == 10'h3FF) ? a : a + 10'd1;
  endfunction

  // Header decode: only in-frame line addresses move the write pointer.
  always_comb begin
    hdr_ok        = (bus.RxAdd < FRAME_WORDS);
    hdr_next_line = sat_add16(bus.RxAdd, LINE_LEN_W);
  end

  // Next-state, pointer, watchdog and write-port decision.
  always_comb begin
    state_d       = state_q;
    wr_add_d      = wr_add_q;
    next_line_d   = next_line_q;
    wd_d          = wd_q;
    fill_cnt_d    = fill_cnt_q;
    miss_count_d  = miss_count_q;
    line_missed_d = 1'b0;
    mem_wr_en_d   = 1'b0;
    mem_wr_add_d  = mem_wr_add_q;
    mem_wr_data_d = mem_wr_data_q;

    if (bus.FrameStart) begin
      // Vsync restarts the frame from any state, without writing.
      state_d      = RX;
      wr_add_d     = 16'd0;
      next_line_d  = LINE_LEN_W;
      wd_d         = 20'd0;
      miss_count_d = 10'd0;
    end else begin
      case (state_q)
        IDLE: begin
          // Wait for the first Vsync; RF traffic is meaningless here.
        end

        RX: begin
          if (bus.RxAddValid) begin
            if (hdr_ok) begin
              wr_add_d    = bus.RxAdd;
              next_line_d = hdr_next_line;
            end
            wd_d = 20'd0;
          end else if (bus.RxValid) begin
            if (wr_add_q < FRAME_WORDS) begin
              mem_wr_en_d   = 1'b1;
              mem_wr_add_d  = wr_add_q;
              mem_wr_data_d = bus.RxData;
              wr_add_d      = wr_add_q + 16'd1;
            end
            wd_d = 20'd0;
          end else if (wd_q == WD_TIMEOUT) begin
            // The expected line never arrived: fill it, or finish the
            // frame if it was the last one.
            if (next_line_q >= FRAME_WORDS) begin
              state_d = DONE;
            end else begin
              state_d    = FILL;
              wr_add_d   = next_line_q;
              fill_cnt_d = 16'd0;
            end
          end else begin
            wd_d = wd_q + 20'd1;
          end
        end

        FILL: begin
          if (bus.RxAddValid) begin
            // A new header means the link is back; drop the fill silently.
            if (hdr_ok) begin
              wr_add_d    = bus.RxAdd;
              next_line_d = hdr_next_line;
            end
            wd_d    = 20'd0;
            state_d = RX;
          end else if (wr_add_q < FRAME_WORDS) begin
            // RF word wins the port and still counts toward the line.
            mem_wr_en_d   = 1'b1;
            mem_wr_add_d  = wr_add_q;
            mem_wr_data_d = bus.RxValid ? bus.RxData : FILL_VALUE;
            wr_add_d      = wr_add_q + 16'd1;
            fill_cnt_d    = fill_cnt_q + 16'd1;
            if (fill_cnt_d == LINE_LEN_W) begin
              next_line_d   = sat_add16(next_line_q, LINE_LEN_W);
              wd_d          = 20'd0;
              line_missed_d = 1'b1;
              miss_count_d  = sat_inc10(miss_count_q);
              state_d       = RX;
            end
          end else begin
            state_d = DONE;
          end
        end

        DONE: begin
          if (bus.LinkLost) begin
            // Re-arm for a new frame without waiting for Vsync.
            state_d     = RX;
            wr_add_d    = 16'd0;
            next_line_d = LINE_LEN_W;
            wd_d        = 20'd0;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase

      // Reaching the end of frame memory ends the frame.
      if (((state_d == RX) || (state_d == FILL)) && (wr_add_d == FRAME_WORDS)) begin
        state_d = DONE;
      end
    end
  end

  // Sequencer state registers.
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      wr_add_q      <= 16'd0;
      next_line_q   <= LINE_LEN_W;
      wd_q          <= 20'd0;
      fill_cnt_q    <= 16'd0;
      miss_count_q  <= 10'd0;
      line_missed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_add_q      <= wr_add_d;
      next_line_q   <= next_line_d;
      wd_q          <= wd_d;
      fill_cnt_q    <= fill_cnt_d;
      miss_count_q  <= miss_count_d;
      line_missed_q <= line_missed_d;
    end
  end

  // Registered memory write port; address and data hold between writes.
  always_ff @(posedge Cclk or negedge rstn) begin
    if (!rstn) begin
      mem_wr_en_q   <= 1'b0;
      mem_wr_add_q  <= 16'd0;
      mem_wr_data_q <= 12'd0;
    end else begin
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_add_q  <= mem_wr_add_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  assign bus.MemWrEn    = mem_wr_en_q;
  assign bus.MemWrAdd   = mem_wr_add_q;
  assign bus.MemWrData  = mem_wr_data_q;
  assign bus.FillActive = (state_q == FILL);
  assign bus.FrameDone  = (state_q == DONE);
  assign bus.LineMissed = line_missed_q;
  assign bus.MissCount  = miss_count_q;

endmodule

// File: tb/tb_rx_line_fill_ctrl.sv
// Directed bench for rx_line_fill_ctrl with a shortened watchdog.
module tb_rx_line_fill_ctrl;

  localparam int TO = 50;

`ifdef RX_FILL_MARK_EN
  localparam logic [11:0] FILLV = 12'h00F;
`else
  localparam logic [11:0] FILLV = 12'h000;
`endif

  logic Cclk;
  logic rstn;
  int   vectors;
  int   miscompares;

  rx_line_fill_ctrl_if bus ();

  rx_line_fill_ctrl #(
    .LINE_LEN  (80),
    .NUM_LINES (480),
    .WD_TIMEOUT(20'(TO))
  ) dut (
    .Cclk(Cclk),
    .rstn(rstn),
    .bus (bus)
  );

  initial Cclk = 1'b0;
  always #5 Cclk = ~Cclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Cclk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_en"},   32'(bus.MemWrEn),    32'd0);
    check({tag, "_add"},  32'(bus.MemWrAdd),   32'd0);
    check({tag, "_data"}, 32'(bus.MemWrData),  32'd0);
    check({tag, "_fill"}, 32'(bus.FillActive), 32'd0);
    check({tag, "_done"}, 32'(bus.FrameDone),  32'd0);
    check({tag, "_miss"}, 32'(bus.LineMissed), 32'd0);
    check({tag, "_cnt"},  32'(bus.MissCount),  32'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rstn = 1'b0;
    bus.FrameStart = 1'b0;
    bus.RxValid    = 1'b0;
    bus.RxData     = 12'd0;
    bus.RxAddValid = 1'b0;
    bus.RxAdd      = 16'd0;
    bus.LinkLost   = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    rstn = 1'b1;

    // IDLE ignores payload words
    bus.RxValid = 1'b1; bus.RxData = 12'h3AA;
    step();
    check("idle_nowrite", 32'(bus.MemWrEn), 32'd0);
    bus.RxValid = 1'b0;

    // Normal line at 0x0050
    bus.FrameStart = 1'b1;
    step();
    bus.FrameStart = 1'b0;
    check("fs_nowrite", 32'(bus.MemWrEn), 32'd0);
    bus.RxAddValid = 1'b1; bus.RxAdd = 16'h0050;
    step();
    bus.RxAddValid = 1'b0;
    check("hdr_nowrite", 32'(bus.MemWrEn), 32'd0);
    for (int i = 0; i < 80; i++) begin
      bus.RxValid = 1'b1; bus.RxData = 12'(i + 1);
      step();
      check("line_en",   32'(bus.MemWrEn),    32'd1);
      check("line_add",  32'(bus.MemWrAdd),   32'h50 + 32'(i));
      check("line_data", 32'(bus.MemWrData),  32'(i + 1));
      check("line_miss", 32'(bus.LineMissed), 32'd0);
    end
    bus.RxValid = 1'b0;

    // Missing line: watchdog expires after TO+1 idle cycles
    for (int j = 0; j < TO; j++) step();
    check("wd_early", 32'(bus.FillActive), 32'd0);
    step();
    check("wd_fill", 32'(bus.FillActive), 32'd1);
    check("wd_nowrite", 32'(bus.MemWrEn), 32'd0);

    // Fill 0x00A0..0x00EF with an RF word granted on fill cycle 10
    for (int k = 0; k < 80; k++) begin
      bus.RxValid = (k == 10); bus.RxData = 12'hABC;
      step();
      check("fill_en",   32'(bus.MemWrEn),   32'd1);
      check("fill_add",  32'(bus.MemWrAdd),  32'hA0 + 32'(k));
      check("fill_data", 32'(bus.MemWrData), (k == 10) ? 32'hABC : 32'(FILLV));
      if (k < 79) check("fill_nomiss", 32'(bus.LineMissed), 32'd0);
    end
    bus.RxValid = 1'b0;
    check("fill_missed", 32'(bus.LineMissed), 32'd1);
    check("fill_cnt",    32'(bus.MissCount),  32'd1);
    check("fill_exit",   32'(bus.FillActive), 32'd0);
    step();
    check("miss_pulse", 32'(bus.LineMissed), 32'd0);
    check("post_fill_en", 32'(bus.MemWrEn), 32'd0);

    // Abort: second fill at 0x00F0 cut short by a header at 0x0140
    for (int j = 0; j < TO; j++) step();
    check("ab_fill", 32'(bus.FillActive), 32'd1);
    repeat (3) step();
    check("ab_add", 32'(bus.MemWrAdd), 32'hF2);
    bus.RxAddValid = 1'b1; bus.RxAdd = 16'h0140;
    step();
    bus.RxAddValid = 1'b0;
    check("ab_exit",  32'(bus.FillActive), 32'd0);
    check("ab_en",    32'(bus.MemWrEn),    32'd0);
    check("ab_nomiss", 32'(bus.LineMissed), 32'd0);
    check("ab_cnt",   32'(bus.MissCount),  32'd1);
    bus.RxValid = 1'b1; bus.RxData = 12'h123;
    step();
    check("ab_wadd",  32'(bus.MemWrAdd),  32'h140);
    check("ab_wdata", 32'(bus.MemWrData), 32'h123);
    // Out-of-frame header is ignored
    bus.RxValid = 1'b0; bus.RxAddValid = 1'b1; bus.RxAdd = 16'h9600;
    step();
    bus.RxAddValid = 1'b0;
    check("oof_en", 32'(bus.MemWrEn), 32'd0);
    bus.RxValid = 1'b1; bus.RxData = 12'h124;
    step();
    bus.RxValid = 1'b0;
    check("oof_add", 32'(bus.MemWrAdd), 32'h141);

    // Frame end: last line 0x95B0..0x95FF
    bus.RxAddValid = 1'b1; bus.RxAdd = 16'h95B0;
    step();
    bus.RxAddValid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      bus.RxValid = 1'b1; bus.RxData = 12'(12'h800 + i);
      step();
      check("end_add",  32'(bus.MemWrAdd),  32'h95B0 + 32'(i));
      check("end_data", 32'(bus.MemWrData), 32'h800 + 32'(i));
      check("end_done", 32'(bus.FrameDone), (i == 79) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      check("done_en",   32'(bus.MemWrEn),   32'd0);
      check("done_hold", 32'(bus.MemWrAdd),  32'h95FF);
      check("done_flag", 32'(bus.FrameDone), 32'd1);
    end
    bus.RxValid = 1'b0;
    bus.LinkLost = 1'b1;
    step();
    bus.LinkLost = 1'b0;
    check("rearm_done", 32'(bus.FrameDone), 32'd0);
    bus.RxValid = 1'b1; bus.RxData = 12'h777;
    step();
    bus.RxValid = 1'b0;
    check("rearm_en",  32'(bus.MemWrEn),  32'd1);
    check("rearm_add", 32'(bus.MemWrAdd), 32'h0);

    // Timeout on the last line goes to DONE instead of FILL
    bus.RxAddValid = 1'b1; bus.RxAdd = 16'h95B0;
    step();
    bus.RxAddValid = 1'b0;
    bus.RxValid = 1'b1; bus.RxData = 12'h001;
    step();
    bus.RxValid = 1'b0;
    check("last_add", 32'(bus.MemWrAdd), 32'h95B0);
    for (int j = 0; j < TO; j++) step();
    check("last_early", 32'(bus.FrameDone), 32'd0);
    step();
    check("last_done", 32'(bus.FrameDone),  32'd1);
    check("last_fill", 32'(bus.FillActive), 32'd0);

    // Asynchronous reset during FILL
    bus.FrameStart = 1'b1;
    step();
    bus.FrameStart = 1'b0;
    check("fs2_done", 32'(bus.FrameDone), 32'd0);
    check("fs2_cnt",  32'(bus.MissCount), 32'd0);
    for (int j = 0; j <= TO; j++) step();
    check("rst_fill", 32'(bus.FillActive), 32'd1);
    repeat (5) step();
    check("rst_add", 32'(bus.MemWrAdd), 32'h54);
    rstn = 1'b0;
    #1;
    check_all_zero("async_rst");
    step();
    rstn = 1'b1;
    bus.RxValid = 1'b1; bus.RxData = 12'h111;
    step();
    bus.RxValid = 1'b0;
    check("rst_idle", 32'(bus.MemWrEn), 32'd0);

    // FrameStart mid-line clears MissCount and restarts at 0x0000
    bus.FrameStart = 1'b1;
    step();
    bus.FrameStart = 1'b0;
    for (int j = 0; j <= TO; j++) step();
    for (int k = 0; k < 80; k++) step();
    check("rs_fadd",  32'(bus.MemWrAdd),  32'h9F);
    check("rs_fdata", 32'(bus.MemWrData), 32'(FILLV));
    check("rs_cnt1",  32'(bus.MissCount), 32'd1);
    bus.RxAddValid = 1'b1; bus.RxAdd = 16'h0050;
    step();
    bus.RxAddValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.RxValid = 1'b1; bus.RxData = 12'(12'h200 + i);
      step();
    end
    check("rs_mid_add", 32'(bus.MemWrAdd), 32'h52);
    bus.FrameStart = 1'b1; bus.RxData = 12'h555;
    step();
    bus.FrameStart = 1'b0;
    check("rs_fs_en",  32'(bus.MemWrEn),   32'd0);
    check("rs_fs_cnt", 32'(bus.MissCount), 32'd0);
    bus.RxData = 12'h556;
    step();
    bus.RxValid = 1'b0;
    check("rs_en",   32'(bus.MemWrEn),   32'd1);
    check("rs_add",  32'(bus.MemWrAdd),  32'h0);
    check("rs_data", 32'(bus.MemWrData), 32'h556);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
